// File: rtl/sm_reg_dump_if.sv
// Register-dump output stream: {addr, data, last} words on a valid/ready handshake.
interface sm_reg_dump_if;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;

  // Producer side (the dump sequencer)
  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  // Consumer side (UART bridge, trace FIFO, testbench)
  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sm_reg_dump.sv
// Register-file dump sequencer for the schoolMIPS debug register port.
// Walks regAddr over 0..REG_COUNT-1 on request or on an idle timer and
// streams each captured {address, data} pair; passes dbgAddr through when idle.
module sm_reg_dump #(
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned PERIOD    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   dbgAddr,
  output logic [4:0]   regAddr,
  input  logic [31:0]  regData,
  sm_reg_dump_if.master stream,
  output logic         busy,
  output logic         done,
  output logic [15:0]  dump_count
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = 32;

  localparam logic [AW-1:0] LAST_IDX  = AW'(REG_COUNT - 1);
  localparam bit            TMR_EN    = (PERIOD != 0);
  localparam logic [TW-1:0] TMR_LAST  = TW'(PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q,      state_d;
  logic [AW-1:0]   idx_q,        idx_d;
  logic [TW-1:0]   tmr_q,        tmr_d;
  logic            out_valid_q,  out_valid_d;
  logic [AW-1:0]   out_addr_q,   out_addr_d;
  logic [DW-1:0]   out_data_q,   out_data_d;
  logic            out_last_q,   out_last_d;
  logic            busy_q,       busy_d;
  logic            done_q,       done_d;
  logic [CW-1:0]   dump_count_q, dump_count_d;

  logic            trigger_c;
  logic            handshake_c;

  // Dump request: explicit start or idle timer expiry; both together still start one dump
  assign trigger_c   = start || (TMR_EN && (tmr_q == TMR_LAST));
  assign handshake_c = out_valid_q && stream.out_ready;

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmr_d        = tmr_q;
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    dump_count_d = dump_count_q;

    case (state_q)
      S_IDLE: begin
        if (trigger_c) begin
          idx_d   = '0;
          tmr_d   = '0;
          state_d = S_SETUP;
        end else if (TMR_EN) begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_SETUP: begin
        // regData is a combinational read of idx, so capture it this cycle
        out_data_d  = regData;
        out_addr_d  = idx_q;
        out_last_d  = (idx_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end

      S_SEND: begin
        if (handshake_c) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_SETUP;
          end
        end
      end

      S_DONE: begin
        dump_count_d = dump_count_q + CW'(1);
        tmr_d        = '0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tmr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dump_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmr_q        <= tmr_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dump_count_q <= dump_count_d;
    end
  end

  // Register port mux: scan index while walking, debug address otherwise
  always_comb begin
    regAddr = dbgAddr;
    if ((state_q == S_SETUP) || (state_q == S_SEND)) begin
      regAddr = idx_q;
    end
  end

  assign stream.out_valid = out_valid_q;
  assign stream.out_addr  = out_addr_q;
  assign stream.out_data  = out_data_q;
  assign stream.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign dump_count       = dump_count_q;

endmodule

// File: doc/sm_reg_dump.md
# sm_reg_dump

Register-file dump sequencer for the schoolMIPS single-cycle CPU. It sits directly downstream of the `sm_top` debug register port, the `regAddr` → `regData` read path. On request or on a periodic timer it walks `regAddr` over registers 0..REG_COUNT-1 and captures each `regData` value. Each value goes out as a {address, data} word on a valid/ready stream, for a UART bridge or trace FIFO. When idle it passes the external debug address through, so the board display keeps working.

## Interface
- `REG_COUNT`, 32: number of registers scanned, 1..32.
- `PERIOD`, 0: idle cycles before an automatic dump; 0 disables the timer.

- `clk`  in  1  CPU clock, the same clock that drives `sm_top`.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  dump request, sampled each rising edge.
- `dbgAddr`  in  5  external debug register address, passed through while idle.
- `regAddr`  out  5  drives `sm_top.regAddr`.
- `regData`  in  32  from `sm_top.regData`; combinational read of `regAddr`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  stream consumer ready.
- `out_addr`  out  5  register index of the current word.
- `out_data`  out  32  register value of the current word.
- `out_last`  out  1  current word is register REG_COUNT-1.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse when a dump completes.
- `dump_count`  out  16  completed dumps; wraps modulo 2^16.

## Operation
- FSM states: IDLE, SETUP, SEND, DONE. A 5-bit index `idx` and a 32-bit idle timer `tmr`.
- IDLE
  - `regAddr` = `dbgAddr` (combinational).
  - The trigger is `start`, or `PERIOD` != 0 with `tmr` == `PERIOD`-1.
  - On the trigger: `idx` ← 0, `tmr` ← 0, go to SETUP.
  - Otherwise, if `PERIOD` != 0, `tmr` increments.
- SETUP
  - `regAddr` = `idx`.
  - At the end of the cycle: `out_data` ← `regData`, `out_addr` ← `idx`, `out_last` ← (`idx` == REG_COUNT-1), `out_valid` ← 1, go to SEND.
- SEND
  - `regAddr` = `idx`.
  - `out_valid`, `out_addr`, `out_data` and `out_last` hold stable until `out_valid` && `out_ready`.
  - On the handshake: `out_valid` ← 0.
  - If `out_last`, go to DONE; otherwise `idx` ← `idx`+1 and go to SETUP.
- DONE
  - `done` = 1 and `regAddr` = `dbgAddr`.
  - `dump_count` increments on the edge that leaves DONE; next state is IDLE; `tmr` restarts from 0.
- `busy` = 1 in SETUP, SEND and DONE.
- `start` outside IDLE is ignored, not queued. When `start` and the timer fire in the same cycle, exactly one dump runs.
- `tmr` holds at 0 outside IDLE.
- The CPU keeps running during a dump. Each word is the register value in its own SETUP cycle; the dump is not an atomic snapshot.

## Timing
- Reset, at the first rising edge with `rst_n` = 0:
  - State IDLE; `idx`, `tmr` = 0.
  - `out_valid`, `out_last`, `busy`, `done` = 0.
  - `out_addr` = 0, `out_data` = 0, `dump_count` = 0.
  - `regAddr` = `dbgAddr`.
- Reset mid-dump abandons the dump. No `done` pulse, no `dump_count` increment; the next dump restarts at register 0.
- Trigger sampled at edge E0 → SETUP during cycle E0..E1 → first `out_valid` high after E1.
- With `out_ready` held at 1:
  - Word k completes its handshake at edge E(2k+2): two cycles per word.
  - The last word (k = REG_COUNT-1) handshakes at E(2·REG_COUNT), i.e. E64 for REG_COUNT = 32.
  - `done` is high during E64..E65; `busy` falls after E65; IDLE resumes after E65.
- Backpressure adds one cycle per stall cycle. `out_valid` never drops without a handshake.
- `out_ready` may be high before `out_valid` rises; the handshake completes on the first edge where both are 1.
- Periodic mode: if the timer fires at edge T, `done` of that dump falls at T + 2·REG_COUNT + 1 (ready = 1). `tmr` then runs from 0, so the next trigger fires `PERIOD` cycles after `done` falls.

## Test plan
- Register model with rf[i] = 32'h100 + i; `start` pulse; `out_ready` = 1.
  - Expect 32 words with `out_addr` 0..31 and `out_data` 32'h100..32'h11F.
  - Expect `out_last` only on addr 31.
  - Expect `done` during cycle E64..E65 (cycle 65 after the start edge); `dump_count` = 1.
- Same setup, with `out_ready` driven by random 30%-high stall patterns.
  - Words, order and count are unchanged.
  - `out_addr` and `out_data` are stable whenever `out_valid` && !`out_ready`.
- `start` pulsed at words 5 and 20 during a dump, and again in the same cycle as `done`: exactly one dump, `dump_count` = 1.
- `PERIOD` = 100, `start` tied low, `out_ready` = 1: the second dump's SETUP begins exactly 100 cycles after the first `done` falls; `dump_count` reaches 3 after the third dump.
- Hold `rst_n` low for 1 cycle at the end of word 10's SETUP cycle, then pulse `start`.
  - Outputs return to reset values at the next edge, with no `done`.
  - The new dump starts at addr 0 with all 32 words.
- `dbgAddr` = 11 while idle: `regAddr` = 11 in IDLE and DONE; `regAddr` = 0..31 only in SETUP and SEND.
